trans_sched8: RTL

TRANS_SCHED8 -- requirements
Module: trans_sched8

---
 rtl/trans_sched8_pkg.sv | 21 ++
 rtl/trans_sched8_rr_pick8.sv | 30 +++
 rtl/trans_sched8.sv | 130 +++++++++++++
 3 files changed

// File: rtl/trans_sched8_pkg.sv
// Shared definitions for the 8-channel round-robin transmission scheduler:
// FSM state encoding, channel count and channel index width.
package trans_sched8_pkg;

    localparam int N_CH  = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // One-hot vector with only bit idx set.
    function automatic logic [N_CH-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/trans_sched8_rr_pick8.sv
// rr_pick8: purely combinational round-robin priority picker.
// Scans ptr+1, ptr+2, ... ptr+8 (mod 8) and reports the first requesting
// channel. ptr itself is scanned last, so a lone request from the last
// winner selects that same channel again.
module rr_pick8
    import trans_sched8_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    logic [IDX_W-1:0] idx;

    // Walk the scan order from lowest to highest priority so the last hit
    // (the nearest channel after ptr) is the one that sticks.
    always_comb begin
        winner = ptr;
        any    = |req;
        idx    = ptr;
        for (int i = N_CH; i >= 1; i--) begin
            idx = ptr + IDX_W'(i);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/trans_sched8.sv
// trans_sched8: round-robin scheduler granting one of 8 channels the shared
// transmission path. {A,B,C} drives the external 8-way mux; oData mirrors
// the selected data bit for monitoring.
// A channel keeps the path while it keeps requesting, for at most HOLD_CYC
// consecutive cycles; then arbitration moves on without an idle gap.
// Optional build macro TRANS_SCHED8_CNT_EN adds the 16-bit oGrantCnt output
// counting every grant entry (wraps at 0xFFFF).
// oState exposes the FSM state for debug/checkers.
module trans_sched8
    import trans_sched8_pkg::*;
#(
    parameter int unsigned HOLD_CYC = 4
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic [N_CH-1:0]  iReq,
    input  logic [N_CH-1:0]  iData,
    output logic             A,
    output logic             B,
    output logic             C,
    output logic [N_CH-1:0]  oGrant,
    output logic             oValid,
    output logic             oData,
    output state_t           oState
`ifdef TRANS_SCHED8_CNT_EN
    ,
    output logic [15:0]      oGrantCnt
`endif
);

    // Dwell limit in the width of the dwell counter (HOLD_CYC is 1..255).
    localparam logic [7:0] HOLD = 8'(HOLD_CYC);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [7:0]       cnt;
    logic [IDX_W-1:0] sel;

    logic [IDX_W-1:0] winner;
    logic             any;
    logic             release_now;
    logic             take_grant;

    rr_pick8 u_pick (
        .req    (iReq),
        .ptr    (ptr),
        .winner (winner),
        .any    (any)
    );

    // Release when the owner drops its request or has used its full dwell;
    // a new grant is taken from IDLE or on release whenever anyone requests.
    always_comb begin
        release_now = (state == GRANT) && (!iReq[ptr] || (cnt >= HOLD));
        take_grant  = any && ((state == IDLE) || release_now);
    end

    // Scheduler FSM with registered select, grant and valid outputs.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state  <= IDLE;
            ptr    <= 3'd7;
            cnt    <= '0;
            sel    <= '0;
            oGrant <= '0;
            oValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_grant) begin
                        state  <= GRANT;
                        ptr    <= winner;
                        cnt    <= 8'd1;
                        sel    <= winner;
                        oGrant <= onehot(winner);
                        oValid <= 1'b1;
                    end
                end
                GRANT: begin
                    if (!release_now) begin
                        cnt <= cnt + 8'd1;
                    end else if (take_grant) begin
                        // Covers both a hand-over and a re-grant of the
                        // same channel: the picker returns ptr when it is
                        // the only requester.
                        ptr    <= winner;
                        cnt    <= 8'd1;
                        sel    <= winner;
                        oGrant <= onehot(winner);
                        oValid <= 1'b1;
                    end else begin
                        // Select lines keep their last value while idle.
                        state  <= IDLE;
                        cnt    <= '0;
                        oGrant <= '0;
                        oValid <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    oGrant <= '0;
                    oValid <= 1'b0;
                end
            endcase
        end
    end

    assign {A, B, C} = sel;
    assign oState    = state;

    // Monitor copy of the external mux output, forced low when nothing is granted.
    assign oData = oValid ? iData[sel] : 1'b0;

`ifdef TRANS_SCHED8_CNT_EN
    logic [15:0] grant_cnt;

    // Count every grant entry; natural 16-bit wrap from 0xFFFF to 0.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            grant_cnt <= '0;
        end else if (take_grant) begin
            grant_cnt <= grant_cnt + 16'd1;
        end
    end

    assign oGrantCnt = grant_cnt;
`endif

endmodule
